// File: rtl/spart_tx_arbiter.sv
// spart_tx_arbiter: round-robin share of the SPART transmitter.
// Grants one byte producer, launches tx, tracks busy, watchdogs launch.
module spart_tx_arbiter #(
  parameter int NREQ    = 4,
  parameter int DW      = 8,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]  ack,
  output logic [2:0]       grant_id,
  output logic             grant_valid,
  output logic             tx_start,
  output logic [DW-1:0]    tx_data,
  input  logic             tx_busy,
  output logic             err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        last_q, last_d;
  logic [2:0]        gid_q, gid_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic              start_q, start_d;
  logic [DW-1:0]     data_q, data_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              err_c;

  logic              found;
  logic [2:0]        win;
  logic [2:0]        idx;
  logic [NREQ-1:0]   req_sh;

  // Rotating scan from the slot after the last grantee, first hit wins.
  always_comb begin
    found  = 1'b0;
    win    = '0;
    idx    = '0;
    req_sh = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx    = 3'((int'(last_q) + k) % NREQ);
      req_sh = req >> idx;
      if (!found && req_sh[0]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  // Next-state, capture and watchdog logic.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gid_d   = gid_q;
    ack_d   = '0;
    start_d = 1'b0;
    data_d  = data_q;
    cnt_d   = cnt_q;
    err_c   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (found && !tx_busy) begin
          data_d  = DW'(req_data >> (int'(win) * DW));
          gid_d   = win;
          ack_d   = NREQ'(1) << win;
          start_d = 1'b1;
          last_d  = win;
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        cnt_d   = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end else if (cnt_q == CW'(TIMEOUT)) begin
          err_c   = 1'b1;
          state_d = IDLE;
        end else if (cnt_q != {CW{1'b1}}) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers, async active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 3'(NREQ - 1);
      gid_q   <= '0;
      ack_q   <= '0;
      start_q <= 1'b0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gid_q   <= gid_d;
      ack_q   <= ack_d;
      start_q <= start_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ack         = ack_q;
  assign grant_id    = gid_q;
  assign grant_valid = (state_q != IDLE);
  assign tx_start    = start_q;
  assign tx_data     = data_q;
  assign err         = err_c;

endmodule

// File: tb/tb_spart_tx_arbiter.sv
// tb_spart_tx_arbiter: directed vectors and corner sequences
// for the round-robin SPART transmit arbiter.
module tb_spart_tx_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  ack;
  logic [2:0]  grant_id;
  logic        grant_valid;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic        err;

  int tests;
  int fails;

  typedef struct {
    logic [3:0]  req;
    logic [31:0] data;
    int          busy;
    logic [3:0]  ack;
    logic [2:0]  gid;
    logic [7:0]  txd;
  } vec_t;

  vec_t tbl[8];

  spart_tx_arbiter #(
    .NREQ(4),
    .DW(8),
    .TIMEOUT(15)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .req_data(req_data),
    .ack(ack),
    .grant_id(grant_id),
    .grant_valid(grant_valid),
    .tx_start(tx_start),
    .tx_data(tx_data),
    .tx_busy(tx_busy),
    .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Issue one request from an IDLE cycle, then model busy for v.busy cycles.
  task automatic run_txn(input vec_t v, input string nm);
    req      = v.req;
    req_data = v.data;
    tx_busy  = 1'b0;
    tick;
    chk({nm, ".ack"}, 32'(ack), 32'(v.ack));
    chk({nm, ".start"}, 32'(tx_start), 32'd1);
    chk({nm, ".gid"}, 32'(grant_id), 32'(v.gid));
    chk({nm, ".data"}, 32'(tx_data), 32'(v.txd));
    chk({nm, ".gv"}, 32'(grant_valid), 32'd1);
    req = '0;
    tick;
    chk({nm, ".ack1"}, 32'(ack), 32'd0);
    chk({nm, ".start1"}, 32'(tx_start), 32'd0);
    tx_busy = 1'b1;
    repeat (v.busy) tick;
    tx_busy = 1'b0;
    #1;
    chk({nm, ".gv_done"}, 32'(grant_valid), 32'd1);
    chk({nm, ".hold"}, 32'(tx_data), 32'(v.txd));
    tick;
    chk({nm, ".idle"}, 32'(grant_valid), 32'd0);
  endtask

  initial begin
    tests    = 0;
    fails    = 0;
    rst      = 1'b1;
    req      = '0;
    req_data = '0;
    tx_busy  = 1'b0;

    tbl[0] = '{4'b0010, 32'h13125A10, 10, 4'b0010, 3'd1, 8'h5A};
    tbl[1] = '{4'b1111, 32'h13121110, 2, 4'b0100, 3'd2, 8'h12};
    tbl[2] = '{4'b0001, 32'h13121110, 1, 4'b0001, 3'd0, 8'h10};
    tbl[3] = '{4'b1001, 32'h13121110, 3, 4'b1000, 3'd3, 8'h13};
    tbl[4] = '{4'b0101, 32'h13121110, 1, 4'b0001, 3'd0, 8'h10};
    tbl[5] = '{4'b0101, 32'h13121110, 2, 4'b0100, 3'd2, 8'h12};
    tbl[6] = '{4'b0101, 32'h13121110, 1, 4'b0001, 3'd0, 8'h10};
    tbl[7] = '{4'b1000, 32'hC3121110, 4, 4'b1000, 3'd3, 8'hC3};

    tick;
    tick;
    chk("rst.ack", 32'(ack), 32'd0);
    chk("rst.gid", 32'(grant_id), 32'd0);
    chk("rst.gv", 32'(grant_valid), 32'd0);
    chk("rst.start", 32'(tx_start), 32'd0);
    chk("rst.data", 32'(tx_data), 32'd0);
    chk("rst.err", 32'(err), 32'd0);
    rst = 1'b0;
    tick;

    for (int i = 0; i < 8; i++) begin
      run_txn(tbl[i], $sformatf("vec%0d", i));
    end

    // Busy-blocked: no grant while tx_busy is high in IDLE.
    tx_busy  = 1'b1;
    req      = 4'b0001;
    req_data = 32'h13121166;
    for (int j = 0; j < 4; j++) begin
      tick;
      chk("blk.noack", 32'(ack), 32'd0);
    end
    tx_busy = 1'b0;
    tick;
    chk("blk.ack", 32'(ack), 32'b0001);
    chk("blk.data", 32'(tx_data), 32'h66);
    req = '0;
    tick;
    tx_busy = 1'b1;
    tick;
    tx_busy = 1'b0;
    tick;
    tick;
    chk("blk.idle", 32'(grant_valid), 32'd0);

    // Busy rising in the same cycle the counter hits TIMEOUT wins.
    req      = 4'b0100;
    req_data = 32'h13771110;
    tick;
    chk("bw.gid", 32'(grant_id), 32'd2);
    req = '0;
    for (int j = 1; j <= 15; j++) tick;
    tick;
    tx_busy = 1'b1;
    #1;
    chk("bw.noerr", 32'(err), 32'd0);
    tick;
    chk("bw.gv", 32'(grant_valid), 32'd1);
    tx_busy = 1'b0;
    tick;
    chk("bw.idle", 32'(grant_valid), 32'd0);

    // Watchdog abort: err in cycle LAUNCH+16, IDLE next, last kept.
    req      = 4'b0010;
    req_data = 32'h13124410;
    tick;
    chk("wd.gid", 32'(grant_id), 32'd1);
    chk("wd.start", 32'(tx_start), 32'd1);
    req = '0;
    for (int j = 1; j <= 16; j++) begin
      tick;
      chk($sformatf("wd.err%0d", j), 32'(err), 32'(j == 16));
    end
    tick;
    chk("wd.idle", 32'(grant_valid), 32'd0);
    chk("wd.err_off", 32'(err), 32'd0);
    run_txn('{4'b0110, 32'h13881110, 2, 4'b0100, 3'd2, 8'h88}, "wd.next");

    // Reset in WAIT_DONE abandons the frame immediately.
    req      = 4'b0010;
    req_data = 32'h1312A510;
    tick;
    chk("mr.gid", 32'(grant_id), 32'd1);
    req = '0;
    tick;
    tx_busy = 1'b1;
    tick;
    tick;
    chk("mr.gv", 32'(grant_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("mr.ack", 32'(ack), 32'd0);
    chk("mr.gid0", 32'(grant_id), 32'd0);
    chk("mr.gv0", 32'(grant_valid), 32'd0);
    chk("mr.start", 32'(tx_start), 32'd0);
    chk("mr.data", 32'(tx_data), 32'd0);
    chk("mr.err", 32'(err), 32'd0);
    tx_busy = 1'b0;
    tick;
    tick;
    rst = 1'b0;

    // All four request continuously: strict rotation from requester 0.
    req      = 4'b1111;
    req_data = 32'h13121110;
    for (int g = 0; g < 6; g++) begin
      int c;
      c = 0;
      while (ack == 4'b0000 && c < 20) begin
        tick;
        c++;
      end
      chk($sformatf("rr%0d.ack", g), 32'(ack), 32'(4'b0001 << (g % 4)));
      chk($sformatf("rr%0d.gid", g), 32'(grant_id), 32'(g % 4));
      chk($sformatf("rr%0d.data", g), 32'(tx_data), 32'(8'h10 + g % 4));
      if (g == 5) req = '0;
      tick;
      chk($sformatf("rr%0d.ack1", g), 32'(ack), 32'd0);
      tx_busy = 1'b1;
      tick;
      tick;
      tx_busy = 1'b0;
      tick;
    end
    tick;
    chk("rr.idle", 32'(grant_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
